// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one OBI-style device port among NrHosts hosts.
// Granted host IDs are queued in order so each device response returns to its issuer.

module mem_port_arbiter_lane #(
    parameter int unsigned IdW = 1,
    parameter int unsigned Id  = 0
) (
    input  logic           accept,
    input  logic [IdW-1:0] win_id,
    input  logic           pop,
    input  logic [IdW-1:0] head_id,
    input  logic           dev_err,
    output logic           gnt,
    output logic           rvalid,
    output logic           err
);
    assign gnt    = accept && (win_id == IdW'(Id));
    assign rvalid = pop && (head_id == IdW'(Id));
    assign err    = rvalid && dev_err;
endmodule

module mem_port_arbiter #(
    parameter int unsigned NrHosts        = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NrHosts-1:0]             host_req_i,
    output logic [NrHosts-1:0]             host_gnt_o,
    input  logic [NrHosts*AddrWidth-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]             host_we_i,
    input  logic [NrHosts*DataWidth/8-1:0] host_be_i,
    input  logic [NrHosts*DataWidth-1:0]   host_wdata_i,
    output logic [NrHosts-1:0]             host_rvalid_o,
    output logic [DataWidth-1:0]           host_rdata_o,
    output logic [NrHosts-1:0]             host_err_o,
    output logic                           dev_req_o,
    input  logic                           dev_gnt_i,
    output logic [AddrWidth-1:0]           dev_addr_o,
    output logic                           dev_we_o,
    output logic [DataWidth/8-1:0]         dev_be_o,
    output logic [DataWidth-1:0]           dev_wdata_o,
    input  logic                           dev_rvalid_i,
    input  logic [DataWidth-1:0]           dev_rdata_i,
    input  logic                           dev_err_i,
    output logic                           spurious_o
);
    localparam int unsigned BeW  = DataWidth / 8;
    localparam int unsigned IdW  = $clog2(NrHosts);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 we;
        logic [BeW-1:0]       be;
        logic [DataWidth-1:0] wdata;
    } host_req_t;

    typedef enum logic {IDLE, LOCKED} lock_state_e;

    host_req_t [NrHosts-1:0] hreq;
    host_req_t               win_req;

    lock_state_e    lock_state_q, lock_state_d;
    logic [IdW-1:0] lock_id_q;
    logic [IdW-1:0] rr_ptr_q;
    logic [IdW-1:0] rr_id, cand, win_id;
    logic           rr_found, any_req, accept;

    logic [IdW-1:0]  tag_mem [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            fifo_full, fifo_empty, push, pop;
    logic [IdW-1:0]  head_id;
    logic            rsp_armed_q, spurious_q;

    // Rotating search starting just above the last winner.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = '0;
        cand     = rr_ptr_q;
        for (int i = 0; i < int'(NrHosts); i++) begin
            cand = (cand == IdW'(NrHosts - 1)) ? '0 : cand + 1'b1;
            if (!rr_found && host_req_i[cand]) begin
                rr_found = 1'b1;
                rr_id    = cand;
            end
        end
    end

    assign win_id     = (lock_state_q == LOCKED) ? lock_id_q : rr_id;
    assign any_req    = (lock_state_q == LOCKED) ? host_req_i[lock_id_q] : rr_found;
    assign fifo_full  = (cnt_q == CntW'(MaxOutstanding));
    assign fifo_empty = (cnt_q == '0);

    assign dev_req_o = any_req && !fifo_full && !rst_i;
    assign accept    = dev_req_o && dev_gnt_i;
    assign push      = accept;
    assign pop       = dev_rvalid_i && !fifo_empty && !rst_i;
    assign head_id   = tag_mem[rd_ptr_q];

    assign win_req     = hreq[win_id];
    assign dev_addr_o  = dev_req_o ? win_req.addr  : '0;
    assign dev_we_o    = dev_req_o ? win_req.we    : 1'b0;
    assign dev_be_o    = dev_req_o ? win_req.be    : '0;
    assign dev_wdata_o = dev_req_o ? win_req.wdata : '0;

    assign host_rdata_o = rst_i ? '0 : dev_rdata_i;
    assign spurious_o   = spurious_q;

    for (genvar h = 0; h < NrHosts; h++) begin : g_host
        assign hreq[h] = '{addr:  host_addr_i[h*AddrWidth +: AddrWidth],
                           we:    host_we_i[h],
                           be:    host_be_i[h*BeW +: BeW],
                           wdata: host_wdata_i[h*DataWidth +: DataWidth]};

        mem_port_arbiter_lane #(
            .IdW (IdW),
            .Id  (h)
        ) u_lane (
            .accept  (accept),
            .win_id  (win_id),
            .pop     (pop),
            .head_id (head_id),
            .dev_err (dev_err_i),
            .gnt     (host_gnt_o[h]),
            .rvalid  (host_rvalid_o[h]),
            .err     (host_err_o[h])
        );
    end

    always_comb begin
        lock_state_d = lock_state_q;
        case (lock_state_q)
            IDLE:   if (dev_req_o && !dev_gnt_i) lock_state_d = LOCKED;
            LOCKED: if (dev_gnt_i)               lock_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_state_q <= IDLE;
            lock_id_q    <= '0;
        end else begin
            lock_state_q <= lock_state_d;
            if (lock_state_q == IDLE && dev_req_o && !dev_gnt_i) lock_id_q <= rr_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr_q] <= win_id;
    end

    // Responses from before a reset arrive while nothing has been issued since;
    // they are discarded without raising the spurious flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q    <= IdW'(NrHosts - 1);
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            rsp_armed_q <= 1'b0;
            spurious_q  <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr_q    <= win_id;
                rsp_armed_q <= 1'b1;
            end
            if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (dev_rvalid_i && fifo_empty && rsp_armed_q) spurious_q <= 1'b1;
        end
    end

    req_held_while_locked: assert property (@(posedge clk_i) disable iff (rst_i)
        (lock_state_q == LOCKED) |-> host_req_i[lock_id_q]);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter that shares one OBI-style memory device port (e.g. the data side of the dual-port SRAM) between several hosts, such as the core data port and a DMA or debug host.
- Accepts requests, issues a single device request per cycle and records the granted host ID in an in-order tag FIFO.
- Routes each device response (rvalid/rdata/err) back to the host that issued it.
- Sits between the hosts and the memory device in the simple system.

Parameters:
- NrHosts, 2, number of requesting hosts (2..8).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; byte-enable width is DataWidth/8.
- MaxOutstanding, 2, tag FIFO depth, i.e. maximum accepted-but-unanswered transactions (power of two, ≥1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- host_req_i  in  NrHosts  per-host request
- host_gnt_o  out  NrHosts  per-host grant (one-hot or zero)
- host_addr_i  in  NrHosts*AddrWidth  packed host addresses, host 0 in LSBs
- host_we_i  in  NrHosts  write enables
- host_be_i  in  NrHosts*DataWidth/8  byte enables
- host_wdata_i  in  NrHosts*DataWidth  write data
- host_rvalid_o  out  NrHosts  per-host response valid (one-hot or zero)
- host_rdata_o  out  DataWidth  response data, broadcast to all hosts
- host_err_o  out  NrHosts  per-host response error
- dev_req_o  out  1  device request
- dev_gnt_i  in  1  device grant
- dev_addr_o  out  AddrWidth  device address
- dev_we_o  out  1  device write enable
- dev_be_o  out  DataWidth/8  device byte enable
- dev_wdata_o  out  DataWidth  device write data
- dev_rvalid_i  in  1  device response valid; asserted for reads and writes, in order
- dev_rdata_i  in  DataWidth  device response data
- dev_err_i  in  1  device response error
- spurious_o  out  1  sticky flag: dev_rvalid_i arrived with the tag FIFO empty

Behaviour:
- Reset (rst_i high at a clock edge):
  - tag FIFO emptied; lock cleared; spurious_o cleared.
  - Priority pointer set to NrHosts-1, so host 0 wins first.
  - While rst_i is high, all outputs are 0: dev_req_o, host_gnt_o, host_rvalid_o, host_err_o, host_rdata_o.
  - Responses still in flight at reset are dropped; they are not counted as spurious.
- Arbitration (combinational):
  - Candidates are hosts with host_req_i=1.
  - The winner is the first candidate searching upward from pointer+1, modulo NrHosts.
  - dev_req_o = any candidate && !fifo_full && !rst_i.
  - dev_addr/we/be/wdata are muxed from the winner; they are 0 when dev_req_o=0.
- Lock state machine, two states:
  - IDLE → LOCKED when dev_req_o=1 and dev_gnt_i=0. The winner ID is captured.
  - In LOCKED, the winner is forced to the captured ID; other requests are ignored.
  - LOCKED → IDLE on dev_gnt_i=1.
  - Hosts keep request and attributes stable until granted; a host dropping req while LOCKED is a protocol violation (simulation assertion).
- Accept, when dev_req_o && dev_gnt_i:
  - host_gnt_o[winner]=1 in the same cycle.
  - Winner ID pushed into the tag FIFO.
  - Pointer updated to the winner.
  - Zero added latency: grant is combinational from dev_gnt_i.
- Response, when dev_rvalid_i=1 with the FIFO not empty:
  - Pop the head ID.
  - host_rvalid_o[head]=1 and host_err_o[head]=dev_err_i in the same cycle.
  - host_rdata_o = dev_rdata_i.
- Spurious response: dev_rvalid_i=1 with the FIFO empty → no host_rvalid_o, spurious_o set (sticky until reset).
- Full FIFO: no new request is issued, even if a pop happens in the same cycle. A simultaneous push and pop in the non-full case keeps the count unchanged.
- Round-robin fairness: every continuously requesting host is granted within NrHosts accepts.

Test Plan:
- Single host, back-to-back reads:
  - Stimulus: host 0 reads 0x100000 then 0x100004; device grants immediately, rvalid one cycle later, rdata 0xA5A5_0001 then 0xA5A5_0002.
  - Required: host_gnt_o=01 on two consecutive cycles; host_rvalid_o=01 with matching data, in order.
- Contention:
  - Stimulus: hosts 0 and 1 request continuously; device always grants.
  - Required: grants alternate 01, 10, 01, 10 starting with host 0 after reset; each response is routed to its issuer.
- Device stall (lock):
  - Stimulus: host 1 requests, dev_gnt_i=0 for 3 cycles; host 0 raises req in cycle 2.
  - Required: dev_addr_o holds host 1's address for all 3 cycles; host 1 is granted first, host 0 next.
- FIFO full:
  - Stimulus: MaxOutstanding=2, device withholds rvalid.
  - Required: after 2 accepts dev_req_o=0; on the first rvalid the pop occurs and dev_req_o is re-asserted in the following cycle.
- Errors and spurious responses:
  - Stimulus: response with dev_err_i=1 for host 1's write.
  - Required: host_err_o=10.
  - Stimulus: then dev_rvalid_i with no outstanding transaction.
  - Required: spurious_o=1, no host_rvalid_o.
- Reset mid-operation:
  - Stimulus: assert rst_i with 2 outstanding transactions.
  - Required: all outputs 0; subsequent late rvalids produce no host_rvalid_o and do not set spurious_o; the first post-reset grant goes to host 0.
